// File: rtl/fu_complete_queue.sv
// Purpose     : per-FU completion buffer; queues finished preg tags and offers the oldest to the CDB.
// Latency     : a tag pushed at edge N is offered from cycle N+1; it is retired when the grant returns.
// Backpressure: full_o stalls FU writeback; a push while full is dropped; a lost grant re-offers the tag.
//
// Ports:
//   clk, reset          - rising-edge clock, asynchronous active-low reset
//   push_i, push_tag_i  - completed result from the FU and its destination preg tag
//   full_o              - queue holds DEPTH entries; FU must hold its writeback
//   squash_i            - mispredict flush, empties the queue
//   complete_o          - completion request to the CDB arbiter
//   complete_tag_o      - tag offered with the request (0 when no request)
//   grant_i             - registered CDB grant for the entry offered last cycle
//   count_o             - current occupancy

`ifndef PREG_NUMBER
`define PREG_NUMBER 64
`endif

module fu_complete_queue #(
   parameter int DEPTH = 4,
   parameter int TAG_W = $clog2(`PREG_NUMBER)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push_i,
   input  logic [TAG_W-1:0]         push_tag_i,
   output logic                     full_o,
   input  logic                     squash_i,
   output logic                     complete_o,
   output logic [TAG_W-1:0]         complete_tag_o,
   input  logic                     grant_i,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [TAG_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [PTR_W-1:0] offer_ptr;
   logic [CNT_W-1:0] count;
   logic             drop_grant;
   logic             g;
   logic             push_acc;
   logic             pop;

   // A grant arriving right after a squash belongs to an entry that no
   // longer exists, so it is masked for that one cycle.
   assign g        = grant_i & ~drop_grant & (count != '0);
   assign full_o   = (count == CNT_W'(DEPTH));
   assign push_acc = push_i & ~full_o & ~squash_i;
   assign pop      = g & ~squash_i;

   // While a grant is returning, mem[head] was already sampled by the CDB at
   // the previous edge; offering it again would broadcast it twice, so the
   // next entry is offered instead. Pointer arithmetic wraps naturally.
   assign offer_ptr      = head + PTR_W'(g);
   assign complete_o     = (count > CNT_W'(g));
   assign complete_tag_o = complete_o ? mem[offer_ptr] : '0;
   assign count_o        = count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head       <= '0;
         tail       <= '0;
         count      <= '0;
         drop_grant <= 1'b0;
      end else if (squash_i) begin
         head       <= '0;
         tail       <= '0;
         count      <= '0;
         drop_grant <= 1'b1;
      end else begin
         drop_grant <= 1'b0;
         if (push_acc) tail <= tail + PTR_W'(1);
         if (pop)      head <= head + PTR_W'(1);
         count <= count + CNT_W'(push_acc) - CNT_W'(pop);
      end
   end

   // Storage is not reset; entries are only visible through count.
   always_ff @(posedge clk) begin
      if (push_acc) mem[tail] <= push_tag_i;
   end

`ifndef SYNTHESIS
   grant_needs_entry: assert property (@(posedge clk) disable iff (!reset)
      grant_i |-> (count != '0 || drop_grant))
      else $error("fu_complete_queue: grant received with empty queue");
`endif

endmodule

// File: tb/tb_fu_complete_queue.sv
module tb_fu_complete_queue;

   localparam int DEPTH = 4;
   localparam int TAG_W = 6;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic             clk;
   logic             reset;
   logic             push_i;
   logic [TAG_W-1:0] push_tag_i;
   logic             full_o;
   logic             squash_i;
   logic             complete_o;
   logic [TAG_W-1:0] complete_tag_o;
   logic             grant_i;
   logic [CNT_W-1:0] count_o;

   int tests_run = 0;
   int fails     = 0;

   // CDB model: samples the offered tag at mid-cycle when it wins
   // arbitration, returns the registered grant in the following cycle.
   logic             arb_win = 1'b0;
   logic             cdb_take = 1'b0;
   logic [TAG_W-1:0] exp_q[$];

   fu_complete_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk            (clk),
      .reset          (reset),
      .push_i         (push_i),
      .push_tag_i     (push_tag_i),
      .full_o         (full_o),
      .squash_i       (squash_i),
      .complete_o     (complete_o),
      .complete_tag_o (complete_tag_o),
      .grant_i        (grant_i),
      .count_o        (count_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard: each tag the CDB samples must be the oldest still expected.
   always @(negedge clk) begin
      if (!reset) begin
         cdb_take = 1'b0;
         exp_q.delete();
      end else begin
         cdb_take = complete_o && arb_win;
         if (complete_o && exp_q.size() == 0) begin
            tests_run++;
            fails++;
            $display("FAIL cdb_dup: offered tag %h with nothing expected", complete_tag_o);
         end else if (cdb_take) begin
            logic [TAG_W-1:0] e;
            e = exp_q.pop_front();
            tests_run++;
            if (complete_tag_o !== e) begin
               fails++;
               $display("FAIL cdb_order: got tag %h, expected %h", complete_tag_o, e);
            end
         end
         if (squash_i) exp_q.delete();
      end
   end

   always @(posedge clk) begin
      #1;
      grant_i = cdb_take;
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic push(input logic [TAG_W-1:0] t, input bit expect_accept);
      next_cycle();
      push_i     = 1'b1;
      push_tag_i = t;
      if (expect_accept) exp_q.push_back(t);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         next_cycle();
         push_i = 1'b0;
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; push_i = 1'b0; push_tag_i = '0; squash_i = 1'b0; grant_i = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      tests_run += 4;
      if (complete_o !== 1'b0)     begin fails++; $display("FAIL reset_complete: got %b want 0", complete_o); end
      if (complete_tag_o !== '0)   begin fails++; $display("FAIL reset_tag: got %h want 0", complete_tag_o); end
      if (full_o !== 1'b0)         begin fails++; $display("FAIL reset_full: got %b want 0", full_o); end
      if (count_o !== '0)          begin fails++; $display("FAIL reset_count: got %0d want 0", count_o); end
      next_cycle();
      reset = 1'b1;
   endtask

   task automatic test_single();
      arb_win = 1'b1;
      push(6'h15, 1'b1);
      next_cycle(); push_i = 1'b0; settle();
      tests_run += 3;
      if (complete_o !== 1'b1)    begin fails++; $display("FAIL single_offer: got %b want 1", complete_o); end
      if (complete_tag_o !== 6'h15) begin fails++; $display("FAIL single_tag: got %h want 15", complete_tag_o); end
      if (count_o !== 1)          begin fails++; $display("FAIL single_count1: got %0d want 1", count_o); end
      next_cycle(); settle();
      tests_run += 2;
      if (complete_o !== 1'b0)    begin fails++; $display("FAIL single_hidden: got %b want 0", complete_o); end
      if (count_o !== 1)          begin fails++; $display("FAIL single_count_grant: got %0d want 1", count_o); end
      next_cycle(); settle();
      tests_run++;
      if (count_o !== 0)          begin fails++; $display("FAIL single_count0: got %0d want 0", count_o); end
   endtask

   task automatic test_streaming();
      int full_seen = 0;
      arb_win = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         push(TAG_W'(i), 1'b1);
         settle();
         if (full_o) full_seen++;
      end
      for (int i = 0; i < 4; i++) begin
         next_cycle(); push_i = 1'b0; settle();
         if (full_o) full_seen++;
      end
      tests_run += 3;
      if (full_seen != 0)    begin fails++; $display("FAIL stream_full: full seen %0d cycles, want 0", full_seen); end
      if (exp_q.size() != 0) begin fails++; $display("FAIL stream_drain: %0d tags never broadcast, want 0", exp_q.size()); end
      if (count_o !== 0)     begin fails++; $display("FAIL stream_count: got %0d want 0", count_o); end
   endtask

   task automatic test_backpressure();
      arb_win = 1'b0;
      push(6'h0A, 1'b1);
      push(6'h0B, 1'b1);
      push(6'h0C, 1'b1);
      push(6'h0D, 1'b1);
      push(6'h0E, 1'b0);
      settle();
      tests_run += 2;
      if (full_o !== 1'b1)  begin fails++; $display("FAIL bp_full: got %b want 1", full_o); end
      if (count_o !== 4)    begin fails++; $display("FAIL bp_count4: got %0d want 4", count_o); end
      next_cycle(); push_i = 1'b0; settle();
      tests_run += 2;
      if (count_o !== 4)    begin fails++; $display("FAIL bp_drop: got count %0d want 4", count_o); end
      if (complete_tag_o !== 6'h0A) begin fails++; $display("FAIL bp_head: got %h want 0a", complete_tag_o); end
      arb_win = 1'b1;
      @(negedge clk); #1; arb_win = 1'b0;
      next_cycle(); settle();
      tests_run += 3;
      if (complete_o !== 1'b1)      begin fails++; $display("FAIL bp_grant_offer: got %b want 1", complete_o); end
      if (complete_tag_o !== 6'h0B) begin fails++; $display("FAIL bp_grant_tag: got %h want 0b", complete_tag_o); end
      if (full_o !== 1'b1)          begin fails++; $display("FAIL bp_full_hold: got %b want 1", full_o); end
      next_cycle(); settle();
      tests_run += 2;
      if (full_o !== 1'b0)  begin fails++; $display("FAIL bp_full_fall: got %b want 0", full_o); end
      if (count_o !== 3)    begin fails++; $display("FAIL bp_count3: got %0d want 3", count_o); end
      arb_win = 1'b1;
      idle(6);
      tests_run++;
      if (count_o !== 0)    begin fails++; $display("FAIL bp_drain: got %0d want 0", count_o); end
   endtask

   task automatic test_lost_arbitration();
      int bad = 0;
      arb_win = 1'b0;
      push(6'h07, 1'b1);
      for (int i = 0; i < 5; i++) begin
         next_cycle(); push_i = 1'b0; settle();
         if (complete_tag_o !== 6'h07 || count_o !== 1) bad++;
      end
      tests_run++;
      if (bad != 0) begin fails++; $display("FAIL lost_hold: %0d bad cycles, want 0", bad); end
      arb_win = 1'b1;
      @(negedge clk); #1; arb_win = 1'b0;
      next_cycle(); settle();
      tests_run++;
      if (complete_o !== 1'b0) begin fails++; $display("FAIL lost_retire_once: got %b want 0", complete_o); end
      next_cycle(); settle();
      tests_run++;
      if (count_o !== 0) begin fails++; $display("FAIL lost_count: got %0d want 0", count_o); end
   endtask

   task automatic test_squash();
      arb_win = 1'b0;
      push(6'h11, 1'b1);
      push(6'h12, 1'b1);
      next_cycle(); push_i = 1'b0;
      // CDB samples the head in the same cycle as the squash; a push here
      // must be discarded too.
      arb_win    = 1'b1;
      squash_i   = 1'b1;
      push_i     = 1'b1;
      push_tag_i = 6'h13;
      @(negedge clk); #1; arb_win = 1'b0;
      next_cycle();
      squash_i   = 1'b0;
      push_i     = 1'b1;
      push_tag_i = 6'h20;
      exp_q.push_back(6'h20);
      settle();
      tests_run += 2;
      if (count_o !== 0)       begin fails++; $display("FAIL squash_count: got %0d want 0", count_o); end
      if (complete_o !== 1'b0) begin fails++; $display("FAIL squash_offer: got %b want 0", complete_o); end
      next_cycle(); push_i = 1'b0; settle();
      tests_run += 3;
      if (complete_o !== 1'b1)      begin fails++; $display("FAIL squash_new_offer: got %b want 1", complete_o); end
      if (complete_tag_o !== 6'h20) begin fails++; $display("FAIL squash_new_tag: got %h want 20", complete_tag_o); end
      if (count_o !== 1)            begin fails++; $display("FAIL squash_new_count: got %0d want 1", count_o); end
      arb_win = 1'b1;
      idle(3);
      tests_run++;
      if (count_o !== 0) begin fails++; $display("FAIL squash_drain: got %0d want 0", count_o); end
   endtask

   task automatic test_async_reset();
      arb_win = 1'b0;
      push(6'h31, 1'b1);
      push(6'h32, 1'b1);
      push(6'h33, 1'b1);
      next_cycle(); push_i = 1'b0; settle();
      tests_run++;
      if (count_o !== 3) begin fails++; $display("FAIL ar_count3: got %0d want 3", count_o); end
      reset = 1'b0;
      #1;
      tests_run += 4;
      if (complete_o !== 1'b0)   begin fails++; $display("FAIL ar_complete: got %b want 0", complete_o); end
      if (complete_tag_o !== '0) begin fails++; $display("FAIL ar_tag: got %h want 0", complete_tag_o); end
      if (full_o !== 1'b0)       begin fails++; $display("FAIL ar_full: got %b want 0", full_o); end
      if (count_o !== 0)         begin fails++; $display("FAIL ar_count: got %0d want 0", count_o); end
      next_cycle();
      reset = 1'b1;
      idle(2);
      tests_run++;
      if (complete_o !== 1'b0) begin fails++; $display("FAIL ar_after: got %b want 0", complete_o); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_streaming();
      test_backpressure();
      test_lost_arbitration();
      test_squash();
      test_async_reset();
      tests_run++;
      if (exp_q.size() != 0) begin fails++; $display("FAIL final_drain: %0d tags pending, want 0", exp_q.size()); end
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
